// File: rtl/lsu_dm_ctrl_pkg.sv
// Shared types for the load/store data-memory controller.
// Size encodings, FSM states and address helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Size 11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz,
                                      input logic [1:0] lo);
    return ((sz == SZ_HALF) && lo[0]) ||
           ((sz == SZ_WORD) && (lo != 2'b00));
  endfunction

  // Low address bits after forcing natural alignment.
  function automatic logic [1:0] align_lo(input logic [1:0] sz,
                                          input logic [1:0] lo);
    logic [1:0] r;
    r = lo;
    if (sz == SZ_HALF) r = {lo[1], 1'b0};
    if (sz == SZ_WORD) r = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/lsu_dm_ctrl_if.sv
// Request/response and data-memory bus of the LSU controller.
// master = CPU plus memory side, slave = controller.
interface lsu_dm_ctrl_if #(
  parameter int ADDR_W = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic [31:0]       dm_dout;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output dm_dout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, dm_addr, dm_din, dm_we
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  dm_dout,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, dm_addr, dm_din, dm_we
  );

endinterface

// File: rtl/lsu_dm_ctrl_lane_mux.sv
// Byte-lane steering: load extract/extend and
// read-modify-write merge for sub-word stores.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select the addressed lane(s), extend loads, merge stores.
  always_comb begin
    b       = ld_word[{lane, 3'b000} +: 8];
    h       = ld_word[{lane[1], 4'b0000} +: 16];
    ld_data = ld_word;
    st_data = wdata;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        ld_data = {{24{~uns & b[7]}}, b};
        st_data = old_word;
        st_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      (size == SZ_HALF): begin
        ld_data = {{16{~uns & h[15]}}, h};
        st_data = old_word;
        st_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = ld_word;
        st_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dm_ctrl.sv
// Load/store controller in front of a word-wide data memory.
// LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning.
module lsu_dm_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic          clk,
  input logic          rst,
  lsu_dm_ctrl_if.slave bus
);

  state_e            state;
  state_e            nxt;
  logic              accept;
  logic [1:0]        sz_in;
  logic [1:0]        lo_in;
  logic              mis_in;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;

  assign accept = bus.req_valid && (state == ST_IDLE);
  assign sz_in  = norm_size(bus.req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign mis_in = misaligned(sz_in, bus.req_addr[1:0]);
  assign lo_in  = bus.req_addr[1:0];
`else
  assign mis_in = 1'b0;
  assign lo_in  = align_lo(sz_in, bus.req_addr[1:0]);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next-state decode; word stores skip the read.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (mis_in)
            nxt = ST_RESP;
          else if (bus.req_we && (sz_in == SZ_WORD))
            nxt = ST_WR;
          else
            nxt = ST_RD;
        end
      end
      ST_RD:   nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:   nxt = ST_RESP;
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= sz_in;
      addr_q  <= {bus.req_addr[ADDR_W-1:2], lo_in};
      wdata_q <= bus.req_wdata;
    end
  end

  // Old word for the read-modify-write merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 word_q <= '0;
    else if (state == ST_RD) word_q <= bus.dm_dout;
  end

  // Response data, loaded on the edge that enters RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_q <= '0;
    else if (accept && mis_in)
      rdata_q <= '0;
    else if ((state == ST_RD) && !we_q)
      rdata_q <= ld_data;
    else if (state == ST_WR)
      rdata_q <= '0;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Error flag follows the same update points as the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept && mis_in)
      err_q <= 1'b1;
    else if ((state == ST_RD && !we_q) || state == ST_WR)
      err_q <= 1'b0;
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  lsu_lane_mux u_lane (
    .ld_word  (bus.dm_dout),
    .old_word (word_q),
    .wdata    (wdata_q),
    .lane     (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.dm_we     = (state == ST_WR);
  assign bus.dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.dm_din    = st_data;

endmodule

// File: tb/tb_lsu_dm_ctrl.sv
// Scoreboard bench for lsu_dm_ctrl with a byte-array memory model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_dm_ctrl;

  logic clk;
  logic rst;

  lsu_dm_ctrl_if #(.ADDR_W(10)) bus();

  lsu_dm_ctrl #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          k;
    int          wes;
    logic [31:0] din;
    bit          chk_din;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [256];
  logic [7:0]  rmem [1024];
  logic        pl_we;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;
  int          cyc;
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_addr[9:2]] <= bus.dm_din;
    else if (pl_we) mem[pl_a] <= pl_d;
  end

  assign bus.dm_dout = mem[bus.dm_addr[9:2]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rword(input int w);
    return {rmem[w+3], rmem[w+2], rmem[w+1], rmem[w]};
  endfunction

  // Preload one word in both the memory and the reference.
  task automatic poke(input int byte_addr, input logic [31:0] d);
    pl_we = 1'b1;
    pl_a  = 8'(byte_addr / 4);
    pl_d  = d;
    for (int i = 0; i < 4; i++)
      rmem[byte_addr + i] = d[8*i +: 8];
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Monitor: one pop per response; counts write strobes in between.
  initial begin
    int          we_cnt;
    logic [31:0] last_din;
    exp_t        e;
    we_cnt   = 0;
    last_din = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_cnt = 0;
        if (bus.dm_we) chk("we_in_reset", 32'(bus.dm_we), 32'd0);
      end else begin
        if (bus.dm_we) begin
          we_cnt++;
          last_din = bus.dm_din;
        end
        if (bus.rsp_valid) begin
          if (q.size() == 0) begin
            chk("stray_rsp", 32'(bus.rsp_valid), 32'd0);
          end else begin
            e = q.pop_front();
            chk("rdata", bus.rsp_rdata, e.rdata);
            chk("err", 32'(bus.rsp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.t + 1), 32'(e.k));
            chk("we_cycles", 32'(we_cnt), 32'(e.wes));
            if (e.chk_din) chk("dm_din", last_din, e.din);
          end
          we_cnt = 0;
        end
      end
    end
  end

  // Issue one request; called and returns at a falling edge.
  task automatic issue(input bit we, input logic [1:0] size,
                       input bit uns, input logic [9:0] addr,
                       input logic [31:0] wd, input bit track,
                       input bit use_exp, input logic [31:0] x_rd,
                       input logic [31:0] x_din);
    bit   acc;
    bit   rdy;
    int   t;
    int   a;
    int   nb;
    int   sz;
    bit   mis;
    exp_t e;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    acc = 1'b0;
    t   = 0;
    for (int n = 0; n < 50 && !acc; n++) begin
      rdy = bus.req_ready;
      t   = cyc + 1;
      @(posedge clk);
      if (rdy) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got none expected accept");
      bus.req_valid = 1'b0;
      return;
    end
    if (track) begin
      sz  = (size == 2'b11) ? 2 : int'(size);
      nb  = 1 << sz;
      a   = int'(addr);
      mis = (a % nb) != 0;
      e.t = t;
      e.chk_din = 1'b0;
      e.din = '0;
      e.err = 1'b0;
      e.rdata = '0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (mis) begin
        e.err = 1'b1;
        e.k   = 1;
        e.wes = 0;
      end else begin
`else
      begin
        a = a - (a % nb);
`endif
        if (we) begin
          for (int i = 0; i < nb; i++)
            rmem[a + i] = wd[8*i +: 8];
          e.k   = (nb == 4) ? 2 : 3;
          e.wes = 1;
          e.din = rword((a / 4) * 4);
          e.chk_din = 1'b1;
        end else begin
          for (int i = 0; i < nb; i++)
            e.rdata = e.rdata | (32'(rmem[a + i]) << (8 * i));
          if (!uns && nb == 1 && e.rdata[7])
            e.rdata = e.rdata | 32'hFFFF_FF00;
          if (!uns && nb == 2 && e.rdata[15])
            e.rdata = e.rdata | 32'hFFFF_0000;
          e.k   = 2;
          e.wes = 0;
        end
      end
      if (use_exp) begin
        if (we) e.din = x_din;
        else e.rdata = x_rd;
      end
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst              = 1'b1;
    pl_we            = 1'b0;
    pl_a             = '0;
    pl_d             = '0;
    cyc              = 0;
    tests            = 0;
    fails            = 0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) poke(4 * i, $urandom);

    poke(16, 32'h8070_60F0);
    issue(0, 2'b00, 0, 10'h013, 0, 1, 1, 32'hFFFF_FF80, 0);
    issue(0, 2'b00, 1, 10'h013, 0, 1, 1, 32'h0000_0080, 0);
    issue(0, 2'b01, 0, 10'h010, 0, 1, 1, 32'h0000_60F0, 0);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);

    poke(16, 32'h1122_3344);
    issue(1, 2'b01, 0, 10'h012, 32'h0000_BEEF, 1, 1, 0,
          32'hBEEF_3344);
    issue(0, 2'b10, 0, 10'h010, 0, 1, 1, 32'hBEEF_3344, 0);
    issue(1, 2'b10, 0, 10'h020, 32'hDEAD_BEEF, 1, 1, 0,
          32'hDEAD_BEEF);
    issue(0, 2'b10, 0, 10'h020, 0, 1, 1, 32'hDEAD_BEEF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 10'h021, 0, 1, 1, 32'h0, 0);
`else
    issue(0, 2'b10, 0, 10'h021, 0, 1, 1, 32'hDEAD_BEEF, 0);
`endif
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);

    poke(48, 32'h5566_7788);
    issue(1, 2'b00, 0, 10'h031, 32'h0000_00AA, 0, 0, 0, 0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_dm_we", 32'(bus.dm_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_mem", mem[12], 32'h5566_7788);

    issue(0, 2'b10, 0, 10'h010, 0, 1, 0, 0, 0);
    issue(0, 2'b00, 1, 10'h020, 0, 1, 0, 0, 0);
    issue(0, 2'b01, 0, 10'h022, 0, 1, 0, 0, 0);
    bus.req_valid = 1'b0;

    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)),
            $urandom, 1, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.req_valid = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_%0d", i), mem[i], rword(4 * i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
